// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide on operand magnitudes, BITS_PER_CYCLE
// bits per iteration, followed by a one-cycle sign fix-up. Divide-by-zero and
// signed overflow are resolved at accept time without iterating.
module muldiv_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res,
    output logic            busy
);
    localparam int unsigned N  = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

    state_t            r_state, w_state_next;
    logic [2:0]        r_op;
    logic              r_sign_a, r_sign_b;
    logic [XLEN-1:0]   r_mag_a, r_mag_b, r_res;
    logic [2*XLEN-1:0] r_acc, w_acc_step;
    logic [CW-1:0]     r_cnt;

    logic              w_accept, w_last;
    logic              w_signed_a, w_signed_b, w_sign_a, w_sign_b;
    logic              w_div0, w_ovf, w_special;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_special_res, w_fix_res;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem;

    // Operand classification for the request presented at the input.
    assign w_signed_a = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    assign w_signed_b = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    assign w_sign_a   = w_signed_a & a[XLEN-1];
    assign w_sign_b   = w_signed_b & b[XLEN-1];
    assign w_mag_a    = w_sign_a ? (~a + 1'b1) : a;
    assign w_mag_b    = w_sign_b ? (~b + 1'b1) : b;

    assign w_div0    = op[2] && (b == '0);
    assign w_ovf     = ((op == 3'd4) || (op == 3'd6)) && (a == MIN_NEG) && (b == '1);
    assign w_special = w_div0 || w_ovf;
    // op[1] separates remainder (REM/REMU) from quotient (DIV/DIVU).
    assign w_special_res = w_div0 ? (op[1] ? a : '1) : (op[1] ? '0 : a);

    assign w_accept = in_valid && (r_state == S_IDLE) && !flush;
    assign w_last   = (r_cnt == CW'(N - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid) w_state_next = w_special ? S_DONE : S_BUSY;
                S_BUSY:  if (w_last) w_state_next = S_FIX;
                S_FIX:   w_state_next = S_DONE;
                S_DONE:  if (out_ready) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // One iteration: BITS_PER_CYCLE shift-add or restoring-divide steps.
    // Multiply keeps {product_hi, multiplier} in r_acc and shifts right;
    // divide keeps {remainder, dividend/quotient} and shifts left.
    always_comb begin
        logic [2*XLEN-1:0] w_it_acc;
        logic [XLEN:0]     w_it_sum;
        w_it_acc = r_acc;
        w_it_sum = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_op[2]) begin
                w_it_sum = {w_it_acc[2*XLEN-1:XLEN], w_it_acc[XLEN-1]} - {1'b0, r_mag_b};
                if (!w_it_sum[XLEN]) begin
                    w_it_acc = {w_it_sum[XLEN-1:0], w_it_acc[XLEN-2:0], 1'b1};
                end else begin
                    w_it_acc = {w_it_acc[2*XLEN-2:0], 1'b0};
                end
            end else begin
                w_it_sum = {1'b0, w_it_acc[2*XLEN-1:XLEN]}
                         + ({1'b0, r_mag_a} & {(XLEN+1){w_it_acc[0]}});
                w_it_acc = {w_it_sum, w_it_acc[XLEN-1:1]};
            end
        end
        w_acc_step = w_it_acc;
    end

    // Sign correction and result selection for the FIX cycle.
    always_comb begin
        w_prod    = (r_sign_a ^ r_sign_b) ? (~r_acc + 1'b1) : r_acc;
        w_quo     = (r_sign_a ^ r_sign_b) ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
        w_rem     = r_sign_a ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
        w_fix_res = '0;
        case (r_op)
            3'd0:             w_fix_res = w_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: w_fix_res = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       w_fix_res = w_quo;
            default:          w_fix_res = w_rem;
        endcase
    end

    // Datapath registers: latch on accept, iterate in BUSY, commit in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_res    <= '0;
        end else if (w_accept) begin
            r_op     <= op;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_mag_a  <= w_mag_a;
            r_mag_b  <= w_mag_b;
            r_acc    <= {{XLEN{1'b0}}, (op[2] ? w_mag_a : w_mag_b)};
            r_cnt    <= '0;
            if (w_special) begin
                r_res <= w_special_res;
            end
        end else if (!flush && (r_state == S_BUSY)) begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt + 1'b1;
        end else if (!flush && (r_state == S_FIX)) begin
            r_res <= w_fix_res;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign res       = r_res;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: three muldiv_unit instances (BITS_PER_CYCLE 1, 2, 4) driven
// with shared stimulus and checked against an arithmetic reference model.
module tb_muldiv_unit;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        out_ready;

    logic        w_in_ready  [3];
    logic        w_out_valid [3];
    logic        w_busy      [3];
    logic [31:0] w_res       [3];

    int checks   = 0;
    int failures = 0;
    int bpc_tab [3] = '{1, 2, 4};

    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready[0]),
        .op(op), .a(a), .b(b), .flush(flush), .out_valid(w_out_valid[0]),
        .out_ready(out_ready), .res(w_res[0]), .busy(w_busy[0]));
    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready[1]),
        .op(op), .a(a), .b(b), .flush(flush), .out_valid(w_out_valid[1]),
        .out_ready(out_ready), .res(w_res[1]), .busy(w_busy[1]));
    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready[2]),
        .op(op), .a(a), .b(b), .flush(flush), .out_valid(w_out_valid[2]),
        .out_ready(out_ready), .res(w_res[2]), .busy(w_busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        p  = '0;
        case (o)
            3'd0: begin p = 64'(ux * uy); return p[31:0];  end
            3'd1: begin p = 64'(sx * sy); return p[63:32]; end
            3'd2: begin p = 64'(sx * uy); return p[63:32]; end
            3'd3: begin p = 64'(ux * uy); return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == MIN_NEG && y == 32'hFFFF_FFFF) return x;
                return 32'(sx / sy);
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                return 32'(ux / uy);
            end
            3'd6: begin
                if (y == 0) return x;
                if (x == MIN_NEG && y == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sx % sy);
            end
            default: begin
                if (y == 0) return x;
                return 32'(ux % uy);
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        return (o >= 3'd4 && y == 0) ||
               ((o == 3'd4 || o == 3'd6) && x == MIN_NEG && y == 32'hFFFF_FFFF);
    endfunction

    function automatic bit all_ready();
        return w_in_ready[0] && w_in_ready[1] && w_in_ready[2];
    endfunction

    // Wait (bounded) for all units idle, then present one request for one edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int waitc = 0;
        while (!all_ready() && waitc < 200) begin
            @(posedge clk); #1;
            waitc++;
        end
        checks++;
        if (waitc >= 200) begin
            failures++;
            $display("FAIL accept_wait: in_ready not all high after %0d cycles", waitc);
        end
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    endtask

    // Issue, then check result and out_valid latency on every instance.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] expv);
        bit [2:0]    seen;
        int          lat [3];
        logic [31:0] got [3];
        int          exp_lat;
        bit          sp;
        sp   = is_special(o, x, y);
        seen = '0;
        lat  = '{0, 0, 0};
        got  = '{32'd0, 32'd0, 32'd0};
        issue(o, x, y);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            for (int d = 0; d < 3; d++) begin
                if (!seen[d] && w_out_valid[d]) begin
                    seen[d] = 1'b1;
                    lat[d]  = cyc;
                    got[d]  = w_res[d];
                    checks++;
                    if (w_in_ready[d] !== 1'b0 || w_busy[d] !== 1'b1) begin
                        failures++;
                        $display("FAIL done_flags bpc=%0d in_ready=%b busy=%b expected 0/1",
                                 bpc_tab[d], w_in_ready[d], w_busy[d]);
                    end
                end
            end
            if (seen == 3'b111) break;
            @(posedge clk); #1;
        end
        for (int d = 0; d < 3; d++) begin
            exp_lat = sp ? 1 : (32 / bpc_tab[d]) + 2;
            checks++;
            if (got[d] !== expv) begin
                failures++;
                $display("FAIL result op=%0d bpc=%0d a=%h b=%h got=%h expected=%h",
                         o, bpc_tab[d], x, y, got[d], expv);
            end
            checks++;
            if (lat[d] !== exp_lat) begin
                failures++;
                $display("FAIL latency op=%0d bpc=%0d got=%0d expected=%0d (0 = never)",
                         o, bpc_tab[d], lat[d], exp_lat);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (w_in_ready[d] !== 1'b1 || w_out_valid[d] !== 1'b0 ||
                w_res[d] !== 32'd0 || w_busy[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_state bpc=%0d in_ready=%b out_valid=%b res=%h busy=%b expected 1/0/0/0",
                         bpc_tab[d], w_in_ready[d], w_out_valid[d], w_res[d], w_busy[d]);
            end
        end
    endtask

    task automatic test_mul();
        do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    endtask

    task automatic test_div();
        do_op(3'd4, -32'sd7, 32'd2, -32'sd3);
        do_op(3'd6, -32'sd7, 32'd2, -32'sd1);
        do_op(3'd5, 32'd7, 32'd2, 32'd3);
        do_op(3'd7, 32'd7, 32'd2, 32'd1);
    endtask

    task automatic test_special();
        do_op(3'd4, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        do_op(3'd6, 32'h1234_5678, 32'd0, 32'h1234_5678);
        do_op(3'd5, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        do_op(3'd7, 32'h1234_5678, 32'd0, 32'h1234_5678);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y;
        int          sel;
        for (int n = 0; n < 60; n++) begin
            o   = 3'($urandom_range(0, 7));
            x   = $urandom;
            y   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) y = 32'd0;
            else if (sel == 1) begin y = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) x = MIN_NEG; end
            else if (sel == 2) y = 32'($urandom_range(1, 15));
            else if (sel == 3) x = 32'($urandom_range(0, 100));
            do_op(o, x, y, model(o, x, y));
        end
    endtask

    task automatic test_back_to_back();
        do_op(3'd5, 32'd1000, 32'd9, 32'd111);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (w_in_ready[d] !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready bpc=%0d in_ready=%b expected 1", bpc_tab[d], w_in_ready[d]);
            end
        end
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        do_op(3'd0, 32'd12345, 32'd6789, 32'd83810205);
    endtask

    task automatic test_backpressure();
        logic [31:0] expv;
        int          waitc = 0;
        expv = 32'hFFFF_FFFE;
        out_ready = 1'b0;
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        while (!(w_out_valid[0] && w_out_valid[1] && w_out_valid[2]) && waitc < 60) begin
            @(posedge clk); #1;
            waitc++;
        end
        checks++;
        if (waitc >= 60) begin
            failures++;
            $display("FAIL bp_done_wait: out_valid not all high after %0d cycles", waitc);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (w_out_valid[d] !== 1'b1 || w_res[d] !== expv || w_in_ready[d] !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_hold bpc=%0d cyc=%0d out_valid=%b res=%h in_ready=%b expected 1/%h/0",
                             bpc_tab[d], c, w_out_valid[d], w_res[d], w_in_ready[d], expv);
                end
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (w_in_ready[d] !== 1'b1 || w_out_valid[d] !== 1'b0 || w_res[d] !== expv) begin
                failures++;
                $display("FAIL bp_release bpc=%0d in_ready=%b out_valid=%b res=%h expected 1/0/%h",
                         bpc_tab[d], w_in_ready[d], w_out_valid[d], w_res[d], expv);
            end
        end
    endtask

    task automatic check_quiet(input string name, input int cycles);
        bit any_valid = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            for (int d = 0; d < 3; d++) if (w_out_valid[d] !== 1'b0) any_valid = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (any_valid) begin
            failures++;
            $display("FAIL %s: out_valid=1 seen, expected 0 for %0d cycles", name, cycles);
        end
    endtask

    task automatic test_flush_reset();
        // Flush at cycle 5 of a DIV.
        issue(3'd4, -32'sd100, 32'd3);
        repeat (4) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (w_in_ready[d] !== 1'b1 || w_out_valid[d] !== 1'b0 || w_busy[d] !== 1'b0) begin
                failures++;
                $display("FAIL flush_idle bpc=%0d in_ready=%b out_valid=%b busy=%b expected 1/0/0",
                         bpc_tab[d], w_in_ready[d], w_out_valid[d], w_busy[d]);
            end
        end
        check_quiet("flush_no_result", 40);

        // Flush together with in_valid in IDLE must not accept.
        flush = 1'b1; in_valid = 1'b1; op = 3'd5; a = 32'd50; b = 32'd5;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (w_in_ready[d] !== 1'b1 || w_busy[d] !== 1'b0) begin
                failures++;
                $display("FAIL flush_no_accept bpc=%0d in_ready=%b busy=%b expected 1/0",
                         bpc_tab[d], w_in_ready[d], w_busy[d]);
            end
        end
        check_quiet("flush_accept_no_result", 12);

        // Asynchronous reset in the middle of a MUL.
        issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #2;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (w_in_ready[d] !== 1'b1 || w_out_valid[d] !== 1'b0 ||
                w_res[d] !== 32'd0 || w_busy[d] !== 1'b0) begin
                failures++;
                $display("FAIL async_reset bpc=%0d in_ready=%b out_valid=%b res=%h busy=%b expected 1/0/0/0",
                         bpc_tab[d], w_in_ready[d], w_out_valid[d], w_res[d], w_busy[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_quiet("reset_no_result", 40);
        do_op(3'd5, 32'd100, 32'd7, 32'd14);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_backpressure();
        test_flush_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
